// File: rtl/audio_io_pkg.sv
// Shared constants and helpers for the audio I/O port: counter width,
// saturating increment and channel-index width.
package audio_io_pkg;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Index width is never below one bit so a single-channel build keeps a port.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO; head is combinational and 0 when empty, push/pop take effect on the edge.
// Push into a full FIFO is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module sample_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
  assign rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/audio_io_port.sv
// Multi-channel ADC->CPU and CPU->DAC frame buffer; reads are combinational, pushes visible next cycle.
// No stalls: full FIFOs drop frames; AUDIO_IO_STATS_EN adds saturating overrun/underrun counters.
module audio_io_port
  import audio_io_pkg::*;
#(
  parameter  int DWIDTH   = 32,
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 4,
  localparam int CHW      = ch_width(CHANNELS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       adc_valid,
  input  logic [CHANNELS*DWIDTH-1:0] adc_frame,
  input  logic                       cpu_in_req,
  input  logic [CHW-1:0]             cpu_in_ch,
  output logic [DWIDTH-1:0]          cpu_in_data,
  output logic                       cpu_in_avail,
  input  logic                       cpu_out_we,
  input  logic [CHW-1:0]             cpu_out_ch,
  input  logic [DWIDTH-1:0]          cpu_out_data,
  output logic                       cpu_out_space,
  output logic                       dac_valid,
  input  logic                       dac_ready,
  output logic [CHANNELS*DWIDTH-1:0] dac_frame,
  output logic [CNT_W-1:0]           in_overrun_cnt,
  output logic [CNT_W-1:0]           out_overrun_cnt,
  output logic [CNT_W-1:0]           dac_underrun_cnt
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

  logic [CHANNELS*DWIDTH-1:0]       in_head;
  logic                             in_full, in_empty, out_full, out_empty;
  logic                             in_pop, commit;
  logic                             in_drop, out_drop, underrun;
  logic [CHANNELS-1:0][DWIDTH-1:0]  stage_q, stage_d;

  // Reading the last channel consumes the head frame.
  assign in_pop   = cpu_in_req && (cpu_in_ch == LAST_CH) && !in_empty;
  assign commit   = cpu_out_we && (cpu_out_ch == LAST_CH);
  assign in_drop  = adc_valid && in_full && !in_pop;
  assign out_drop = commit && out_full && !dac_ready;
  assign underrun = dac_ready && out_empty;

  assign cpu_in_avail  = !in_empty;
  assign cpu_out_space = !out_full;
  assign dac_valid     = !out_empty;

  sample_fifo #(.WIDTH(CHANNELS*DWIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (adc_valid),
    .pop_i   (in_pop),
    .din_i   (adc_frame),
    .full_o  (in_full),
    .empty_o (in_empty),
    .head_o  (in_head)
  );

  always_comb begin
    cpu_in_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cpu_in_ch == CHW'(c)) cpu_in_data = in_head[c*DWIDTH +: DWIDTH];
    end
  end

  // The committed frame is the staging set with this cycle's write folded in.
  always_comb begin
    stage_d = stage_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cpu_out_we && (cpu_out_ch == CHW'(c))) stage_d[c] = cpu_out_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  sample_fifo #(.WIDTH(CHANNELS*DWIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (commit),
    .pop_i   (dac_ready),
    .din_i   (stage_d),
    .full_o  (out_full),
    .empty_o (out_empty),
    .head_o  (dac_frame)
  );

`ifdef AUDIO_IO_STATS_EN
  logic [CNT_W-1:0] in_ovr_q, in_ovr_d, out_ovr_q, out_ovr_d, und_q, und_d;

  assign in_ovr_d  = in_drop  ? sat_inc(in_ovr_q)  : in_ovr_q;
  assign out_ovr_d = out_drop ? sat_inc(out_ovr_q) : out_ovr_q;
  assign und_d     = underrun ? sat_inc(und_q)     : und_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_ovr_q  <= '0;
      out_ovr_q <= '0;
      und_q     <= '0;
    end else begin
      in_ovr_q  <= in_ovr_d;
      out_ovr_q <= out_ovr_d;
      und_q     <= und_d;
    end
  end

  assign in_overrun_cnt   = in_ovr_q;
  assign out_overrun_cnt  = out_ovr_q;
  assign dac_underrun_cnt = und_q;
`else
  logic unused_stats;
  assign unused_stats     = ^{in_drop, out_drop, underrun};
  assign in_overrun_cnt   = '0;
  assign out_overrun_cnt  = '0;
  assign dac_underrun_cnt = '0;
`endif

endmodule
